uart2wifi_core_uart_tx: RTL and testbench
=========================================

// Module: uart2wifi_core_uart_tx
// PURPOSE
//  UART serial transmitter: the outbound counterpart of the core's UART receive path.
//  Takes parallel bytes over a valid/ready handshake and serialises them on tx:
//  start bit, LSB-first data bits, optional parity bit, then stop bit(s).
//  Bit timing comes from the baudtick strobe of uart2wifi_core_baudrategen.
//  Sits between the core FSM/SRAM datapath and the board UART pin.
// PARAMETERS
//  DATA_BITS  8  data bits per frame; legal values 5..8
//  STOP_BITS  1  stop bits per frame; legal values 1 or 2
// PORTS
//  clk       in   1          system clock
//  rst       in   1          asynchronous, active-high reset
//  baudtick  in   1          one-cycle strobe per bit period
//  tx_data   in   DATA_BITS  byte to send; sampled when tx_valid && tx_ready
//  tx_valid  in   1          tx_data is valid
//  tx_ready  out  1          holding register empty; a byte can be accepted
//  tx        out  1          serial line, idle high; registered output
//  tx_busy   out  1          a frame is in progress (any state except IDLE)
//  tx_done   out  1          one-cycle pulse when the last stop bit ends
// BEHAVIOUR
//  - Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, holding empty,
//    bit/stop counters=0.
//  - Handshake: a byte is accepted on any posedge where tx_valid && tx_ready. It loads
//    the 1-entry holding register and sets pending. tx_ready = !pending (registered),
//    so it drops the cycle after acceptance.
//  - FSM: IDLE, START, DATA, PARITY, STOP. All state and tx changes happen only on
//    cycles with baudtick=1. Each bit is held for exactly one baudtick interval.
//  - IDLE: tx=1. On baudtick with pending=1: move holding to shift reg, clear pending,
//    go to START, tx<=0.
//  - START: on baudtick go to DATA with tx<=shift[0] and bit_cnt=0.
//  - DATA: on baudtick, if bit_cnt==DATA_BITS-1 go to PARITY (tx<=parity) or STOP
//    (tx<=1). Otherwise shift right, increment bit_cnt, and drive the next bit.
//  - PARITY: on baudtick go to STOP, tx<=1.
//  - STOP: lasts STOP_BITS ticks. On its final tick, pulse tx_done. Then:
//    - pending=1: go straight to START with tx<=0 (back-to-back frames, no idle gap);
//    - pending=0: go to IDLE.
//  - Buffering: the holding register can be refilled while a frame is in progress.
//    A second write while pending=1 is impossible because tx_ready=0.
//  - Start latency: a frame starts at the first baudtick strictly after the accept
//    cycle. An accept on the same cycle as a baudtick waits for the next tick.
//  - Line timing: a frame occupies 1+DATA_BITS+P+STOP_BITS tick intervals, where P=1
//    when parity is compiled in and 0 otherwise.
//  - baudtick asserted for several consecutive cycles: each asserted cycle counts as
//    one tick. This is legal but out of spec.
//  - Reset mid-frame: the frame is aborted immediately (async). tx returns high and
//    the pending byte is discarded. No tx_done is issued.
//  - tx_data is don't-care when tx_valid=0. tx_valid may drop without acceptance.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//   - PARITY state is used; parity bit = ^data, i.e. even parity (bit set when the
//     number of 1s is odd);
//   - parity is computed at load from the holding register.
//  UART_TX_PARITY_EN undefined:
//   - PARITY state and logic are absent; DATA goes directly to STOP.
// TESTING
//  Bench generates a baudtick pulse every 11 clk. Checks sample tx mid-interval.
//  1) Reset:
//     - assert rst mid-frame -> tx=1, tx_ready=1, tx_busy=0 within the same cycle;
//     - no tx_done pulse.
//  2) Single byte, no parity, 1 stop: send 0xA5 ->
//     - tx sequence 0,1,0,1,0,0,1,0,1,1 (10 bits x 11 clk);
//     - one tx_done pulse, then IDLE.
//  3) Back-to-back: send 0x00, then 0xFF while the first frame is busy ->
//     - tx_ready drops then returns at the 0x00 start bit;
//     - the 0xFF start bit immediately follows the 0x00 stop bit (no idle gap);
//     - two tx_done pulses, 110 clk apart.
//  4) Accept coincident with baudtick in IDLE -> start bit begins at the following
//     tick (11 clk later), not the current one.
//  5) With UART_TX_PARITY_EN, send 0x07 -> parity bit=1; send 0xA5 -> parity bit=0;
//     frame length 11 bits.
//  6) STOP_BITS=2, send 0x3C -> tx held high for 22 clk before tx_done; tx_valid held
//     with tx_ready=0 -> no second load until tx_ready=1.

Source files
------------

// File: rtl/uart2wifi_core_uart_tx.sv
// UART serial transmitter: valid/ready byte input, start + LSB-first data + optional parity + stop bits.
// Optional even-parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart2wifi_core_uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baudtick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t                 state_r,    state_nxt_s;
    logic [DATA_BITS-1:0]   shift_r,    shift_nxt_s;
    logic [DATA_BITS-1:0]   hold_r,     hold_nxt_s;
    logic                   pending_r,  pending_nxt_s;
    logic [2:0]             bit_cnt_r,  bit_cnt_nxt_s;
    logic                   stop_cnt_r, stop_cnt_nxt_s;
    logic                   tx_nxt_s;
    logic                   done_nxt_s;
    logic                   load_s;
`ifdef UART_TX_PARITY_EN
    logic                   parity_r,   parity_nxt_s;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    // Next-state, datapath and output decode; everything moves only on baudtick.
    always_comb begin
        state_nxt_s    = state_r;
        shift_nxt_s    = shift_r;
        hold_nxt_s     = hold_r;
        pending_nxt_s  = pending_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        stop_cnt_nxt_s = stop_cnt_r;
        tx_nxt_s       = tx;
        done_nxt_s     = 1'b0;
        load_s         = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt_s   = parity_r;
`endif

        if (tx_valid && tx_ready) begin
            hold_nxt_s    = tx_data;
            pending_nxt_s = 1'b1;
        end else begin
            hold_nxt_s    = hold_r;
        end

        if (baudtick) begin
            case (state_r)
                ST_IDLE: begin
                    if (pending_r) begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_START;
                        tx_nxt_s    = 1'b0;
                    end else begin
                        tx_nxt_s    = 1'b1;
                    end
                end
                ST_START: begin
                    state_nxt_s   = ST_DATA;
                    tx_nxt_s      = shift_r[0];
                    bit_cnt_nxt_s = 3'd0;
                end
                ST_DATA: begin
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt_s    = ST_PARITY;
                        tx_nxt_s       = parity_r;
`else
                        state_nxt_s    = ST_STOP;
                        tx_nxt_s       = 1'b1;
                        stop_cnt_nxt_s = 1'b0;
`endif
                    end else begin
                        shift_nxt_s   = shift_r >> 1;
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        tx_nxt_s      = shift_r[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    state_nxt_s    = ST_STOP;
                    tx_nxt_s       = 1'b1;
                    stop_cnt_nxt_s = 1'b0;
                end
`endif
                ST_STOP: begin
                    if (stop_cnt_r == LAST_STOP) begin
                        done_nxt_s = 1'b1;
                        if (pending_r) begin
                            // Refilled holding register: next start bit follows with no idle gap.
                            load_s      = 1'b1;
                            state_nxt_s = ST_START;
                            tx_nxt_s    = 1'b0;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            tx_nxt_s    = 1'b1;
                        end
                    end else begin
                        stop_cnt_nxt_s = stop_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    tx_nxt_s    = 1'b1;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end

        // Acceptance needs pending=0 and a load needs pending=1, so they never collide.
        if (load_s) begin
            shift_nxt_s   = hold_r;
            pending_nxt_s = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_nxt_s  = even_parity(hold_r);
`endif
        end else begin
            shift_nxt_s   = shift_nxt_s;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            hold_r     <= '0;
            pending_r  <= 1'b0;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            hold_r     <= hold_nxt_s;
            pending_r  <= pending_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            stop_cnt_r <= stop_cnt_nxt_s;
            tx         <= tx_nxt_s;
            tx_ready   <= !pending_nxt_s;
            tx_busy    <= (state_nxt_s != ST_IDLE);
            tx_done    <= done_nxt_s;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart2wifi_core_uart_tx.sv
// Randomized bench for uart2wifi_core_uart_tx: frame-level reference model, baudtick every 11 clk.
// Two instances: default (1 stop bit) and STOP_BITS=2; follows UART_TX_PARITY_EN like the RTL.
module tb_uart2wifi_core_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
    localparam int NB = 11;
    int a5_seq [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    localparam int PB = 0;
    localparam int NB = 10;
    int a5_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
    localparam int FL = 1 + 8 + PB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baudtick = 1'b0;
    logic [7:0] tx_data = 8'h00, tx_data2 = 8'h00;
    logic       tx_valid = 1'b0, tx_valid2 = 1'b0;
    logic       tx_ready, tx, tx_busy, tx_done;
    logic       tx_ready2, tx2, tx_busy2, tx_done2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tick_cnt = 0;
    int done_cyc [$];

    uart2wifi_core_uart_tx dut (
        .clk(clk), .rst(rst), .baudtick(baudtick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart2wifi_core_uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .baudtick(baudtick), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a bit list walked one entry per tick.
    typedef struct packed {
        logic        pending;
        logic [7:0]  hold;
        logic        active;
        logic [4:0]  idx;
        logic [4:0]  len;
        logic [15:0] bits;
        logic        done;
    } mst_t;

    mst_t m1, m2;

    function automatic mst_t mstep(input mst_t s, input logic tick, input logic acc,
                                   input logic [7:0] d, input int nstop);
        mst_t n;
        int   k;
        n = s;
        n.done = 1'b0;
        if (tick && s.active) begin
            n.idx = s.idx + 5'd1;
            if (n.idx == s.len) begin
                n.active = 1'b0;
                n.done   = 1'b1;
            end
        end
        if (tick && !n.active && s.pending) begin
            n.bits    = '1;
            n.bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) n.bits[1 + i] = s.hold[i];
            k = 9;
            if (PB == 1) begin
                n.bits[9] = ^s.hold;
                k = 10;
            end
            n.len     = 5'(k + nstop);
            n.idx     = 5'd0;
            n.active  = 1'b1;
            n.pending = 1'b0;
        end
        if (acc) begin
            n.pending = 1'b1;
            n.hold    = d;
        end
        return n;
    endfunction

    function automatic logic exp_tx(input mst_t s);
        return s.active ? s.bits[s.idx] : 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= '0;
            m2 <= '0;
        end else begin
            m1 <= mstep(m1, baudtick, tx_valid && !m1.pending, tx_data, 1);
            m2 <= mstep(m2, baudtick, tx_valid2 && !m2.pending, tx_data2, 2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: compare on the falling edge, then set up the tick for the next rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            chk("tx", {31'd0, tx}, {31'd0, exp_tx(m1)});
            chk("ready", {31'd0, tx_ready}, {31'd0, !m1.pending});
            chk("busy", {31'd0, tx_busy}, {31'd0, m1.active});
            chk("done", {31'd0, tx_done}, {31'd0, m1.done});
            chk("tx2", {31'd0, tx2}, {31'd0, exp_tx(m2)});
            chk("ready2", {31'd0, tx_ready2}, {31'd0, !m2.pending});
            chk("busy2", {31'd0, tx_busy2}, {31'd0, m2.active});
            chk("done2", {31'd0, tx_done2}, {31'd0, m2.done});
            if (tx_done) done_cyc.push_back(cyc);
        end
        tick_cnt = (tick_cnt == 10) ? 0 : tick_cnt + 1;
        baudtick = (tick_cnt == 10);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((m1.active || m1.pending || m2.active || m2.pending) && n < 600) begin
            step();
            n++;
        end
        chk(tag, {31'd0, n < 600}, 32'd1);
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (m1.pending && n < 600) begin
            step();
            n++;
        end
        chk("send_ready_to", {31'd0, n < 600}, 32'd1);
        tx_valid = 1'b1;
        tx_data  = d;
        step();
        tx_valid = 1'b0;
    endtask

    initial begin
        int n;
        int pct [3] = '{20, 100, 5};

        // Reset values
        rst = 1'b1;
        repeat (3) step();
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        repeat (15) step();

        // Single 0xA5 frame sampled mid-bit
        send(8'hA5);
        n = 0;
        while (!m1.active && n < 40) begin
            step();
            n++;
        end
        chk("a5_start_to", {31'd0, n < 40}, 32'd1);
        repeat (5) step();
        for (int k = 0; k < NB; k++) begin
            chk("a5_bit", {31'd0, tx}, 32'(a5_seq[k]));
            repeat (11) step();
        end
        wait_idle("a5_idle");

        // Back-to-back 0x00 then 0xFF
        done_cyc.delete();
        send(8'h00);
        send(8'hFF);
        wait_idle("b2b_idle");
        repeat (3) step();
        chk("b2b_ndone", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2) chk("b2b_gap", 32'(done_cyc[1] - done_cyc[0]), 32'(11 * FL));

        // Accept on a tick cycle in IDLE: start waits for the following tick
        n = 0;
        while (!baudtick && n < 20) begin
            step();
            n++;
        end
        tx_valid = 1'b1;
        tx_data  = 8'(($urandom));
        step();
        tx_valid = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        chk("accept_tick_latency", 32'(n), 32'd11);
        wait_idle("lat_idle");

        // Two stop bits with tx_valid held through tx_ready=0
        tx_valid2 = 1'b1;
        tx_data2  = 8'h3C;
        repeat (60) step();
        tx_data2  = 8'h81;
        repeat (200) step();
        tx_valid2 = 1'b0;

        // Asynchronous reset mid-frame
        send(8'h5A);
        tx_valid2 = 1'b1;
        tx_data2  = 8'(($urandom));
        n = 0;
        while (!(m1.active && m1.idx == 5'd4) && n < 200) begin
            step();
            n++;
        end
        chk("midframe_to", {31'd0, n < 200}, 32'd1);
        tx_valid2 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", {31'd0, tx}, 32'd1);
        chk("arst_ready", {31'd0, tx_ready}, 32'd1);
        chk("arst_busy", {31'd0, tx_busy}, 32'd0);
        chk("arst_done", {31'd0, tx_done}, 32'd0);
        chk("arst_tx2", {31'd0, tx2}, 32'd1);
        chk("arst_busy2", {31'd0, tx_busy2}, 32'd0);
        step();
        step();
        rst = 1'b0;
        repeat (40) step();

        // Randomized traffic at several offered loads
        for (int ph = 0; ph < 3; ph++) begin
            repeat (700) begin
                step();
                tx_valid  = ($urandom_range(0, 99) < pct[ph]);
                tx_data   = 8'(($urandom));
                tx_valid2 = ($urandom_range(0, 99) < pct[ph]);
                tx_data2  = 8'(($urandom));
            end
        end
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
        wait_idle("final_idle");
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
